// File: rtl/top_level_reduction_pkg.sv
// Shared widths and types for the 5x5 Wallace multiplier block.
// Product width covers 31*31 = 961 without overflow.
package top_level_reduction_pkg;

   localparam int OP_W   = 5;
   localparam int PROD_W = 10;

   typedef logic [OP_W-1:0]   operand_t;
   typedef logic [PROD_W-1:0] product_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder: purely combinational, zero latency.
// No handshake; output follows inputs.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: purely combinational, zero latency.
// No handshake; output follows inputs.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b;
   assign cout = a & b;

endmodule

// File: rtl/top_level_reduction_5x5.sv
// Registered 5x5 unsigned multiplier: Wallace reduction plus ripple CPA, P valid 1 cycle after A/B.
// No backpressure: a new operand pair is accepted every cycle.
module top_level_reduction_5x5
   import top_level_reduction_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   A,
   input  logic [OP_W-1:0]   B,
   output logic [PROD_W-1:0] P
);

   // pp[i][j] carries weight 2^(i+j)
   logic [OP_W-1:0][OP_W-1:0] pp;

   for (genvar i = 0; i < OP_W; i++) begin : g_pp_row
      for (genvar j = 0; j < OP_W; j++) begin : g_pp_col
         assign pp[i][j] = A[j] & B[i];
      end
   end

   // Stage 1: heights 1,2,3,4,5,4,3,2,1 -> 1,2,1,3,4,3,2,3,1
   logic [0:0] s1_col0, s1_col2, s1_col8;
   logic [1:0] s1_col1, s1_col6;
   logic [2:0] s1_col3, s1_col5, s1_col7;
   logic [3:0] s1_col4;

   assign s1_col0[0]   = pp[0][0];
   assign s1_col1      = {pp[1][0], pp[0][1]};
   assign s1_col3[1]   = pp[3][0];
   assign s1_col4[2:1] = {pp[4][0], pp[3][1]};
   assign s1_col5[1]   = pp[4][1];
   assign s1_col7[2:1] = {pp[4][3], pp[3][4]};
   assign s1_col8[0]   = pp[4][4];

   full_adder u_s1_fa2 (.a(pp[0][2]), .b(pp[1][1]), .cin(pp[2][0]), .sum(s1_col2[0]), .cout(s1_col3[0]));
   full_adder u_s1_fa3 (.a(pp[0][3]), .b(pp[1][2]), .cin(pp[2][1]), .sum(s1_col3[2]), .cout(s1_col4[0]));
   full_adder u_s1_fa4 (.a(pp[0][4]), .b(pp[1][3]), .cin(pp[2][2]), .sum(s1_col4[3]), .cout(s1_col5[0]));
   full_adder u_s1_fa5 (.a(pp[1][4]), .b(pp[2][3]), .cin(pp[3][2]), .sum(s1_col5[2]), .cout(s1_col6[0]));
   full_adder u_s1_fa6 (.a(pp[2][4]), .b(pp[3][3]), .cin(pp[4][2]), .sum(s1_col6[1]), .cout(s1_col7[0]));

   // Stage 2: -> 1,2,1,1,3,2,3,1,2
   logic [0:0] s2_col0, s2_col2, s2_col3, s2_col7;
   logic [1:0] s2_col1, s2_col5, s2_col8;
   logic [2:0] s2_col4, s2_col6;

   assign s2_col0      = s1_col0;
   assign s2_col1      = s1_col1;
   assign s2_col2      = s1_col2;
   assign s2_col4[2]   = s1_col4[3];
   assign s2_col6[2:1] = s1_col6;
   assign s2_col8[1]   = s1_col8[0];

   full_adder u_s2_fa3 (.a(s1_col3[0]), .b(s1_col3[1]), .cin(s1_col3[2]), .sum(s2_col3[0]), .cout(s2_col4[0]));
   full_adder u_s2_fa4 (.a(s1_col4[0]), .b(s1_col4[1]), .cin(s1_col4[2]), .sum(s2_col4[1]), .cout(s2_col5[0]));
   full_adder u_s2_fa5 (.a(s1_col5[0]), .b(s1_col5[1]), .cin(s1_col5[2]), .sum(s2_col5[1]), .cout(s2_col6[0]));
   full_adder u_s2_fa7 (.a(s1_col7[0]), .b(s1_col7[1]), .cin(s1_col7[2]), .sum(s2_col7[0]), .cout(s2_col8[0]));

   // Stage 3: -> 1,2,1,1,1,2,2,2,2; the col5 pair needs a half adder because col4 sends it a carry
   logic [0:0] s3_col0, s3_col2, s3_col3, s3_col4;
   logic [1:0] s3_col1, s3_col5, s3_col6, s3_col7, s3_col8;

   assign s3_col0    = s2_col0;
   assign s3_col1    = s2_col1;
   assign s3_col2    = s2_col2;
   assign s3_col3    = s2_col3;
   assign s3_col7[1] = s2_col7[0];
   assign s3_col8    = s2_col8;

   full_adder u_s3_fa4 (.a(s2_col4[0]), .b(s2_col4[1]), .cin(s2_col4[2]), .sum(s3_col4[0]), .cout(s3_col5[0]));
   half_adder u_s3_ha5 (.a(s2_col5[0]), .b(s2_col5[1]), .sum(s3_col5[1]), .cout(s3_col6[0]));
   full_adder u_s3_fa6 (.a(s2_col6[0]), .b(s2_col6[1]), .cin(s2_col6[2]), .sum(s3_col6[1]), .cout(s3_col7[0]));

   // Final carry-propagate add of the two remaining rows
   product_t           row_a, row_b, cpa_sum, p_next;
   logic [PROD_W:0]    cpa_c;

   assign row_a = {1'b0, s3_col8[0], s3_col7[0], s3_col6[0], s3_col5[0],
                   s3_col4[0], s3_col3[0], s3_col2[0], s3_col1[0], s3_col0[0]};
   assign row_b = {1'b0, s3_col8[1], s3_col7[1], s3_col6[1], s3_col5[1],
                   3'b000, s3_col1[1], 1'b0};
   assign cpa_c[0] = 1'b0;

   for (genvar k = 0; k < PROD_W; k++) begin : g_cpa
      full_adder u_fa (.a(row_a[k]), .b(row_b[k]), .cin(cpa_c[k]), .sum(cpa_sum[k]), .cout(cpa_c[k+1]));
   end

   // Top carry is always 0 (961 < 1024); OR-ing it in keeps the net from dangling
   assign p_next = {cpa_sum[PROD_W-1] | cpa_c[PROD_W], cpa_sum[PROD_W-2:0]};

   always_ff @(posedge clk) begin
      if (rst) P <= '0;
      else     P <= p_next;
   end

endmodule

// File: tb/tb_top_level_reduction_5x5.sv
// Self-checking bench for top_level_reduction_5x5 against an arithmetic product model.
// Directed, exhaustive and randomized operand/reset stimulus.
module tb_top_level_reduction_5x5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] A   = '0;
   logic [4:0] B   = '0;
   logic [9:0] P;

   int n_vec  = 0;
   int n_miss = 0;

   top_level_reduction_5x5 dut (.clk(clk), .rst(rst), .A(A), .B(B), .P(P));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: P=%0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] ref_prod(input int a, input int b, input bit r);
      int p;
      p = r ? 0 : a * b;
      return p[9:0];
   endfunction

   // Drive one operand pair (and reset level) for one edge, then check P after that edge
   task automatic step(input int a, input int b, input bit r, input string tag);
      @(negedge clk);
      A   = a[4:0];
      B   = b[4:0];
      rst = r;
      @(posedge clk);
      #1;
      check_val(tag, P, ref_prod(a, b, r));
   endtask

   int dir_a [9] = '{22, 11, 23, 10,  0, 31,  1, 31, 16};
   int dir_b [9] = '{22, 31,  5, 14, 23, 31, 31,  1, 16};
   int seq_a [3] = '{3, 7, 30};
   int seq_b [3] = '{7, 3, 29};

   initial begin
      // Reset with maximum operands present, then release
      step(31, 31, 1'b1, "reset_edge0");
      step(31, 31, 1'b1, "reset_edge1");
      step(31, 31, 1'b0, "first_after_reset");

      foreach (dir_a[i]) step(dir_a[i], dir_b[i], 1'b0, $sformatf("directed_%0dx%0d", dir_a[i], dir_b[i]));

      foreach (seq_a[i]) step(seq_a[i], seq_b[i], 1'b0, $sformatf("back_to_back_%0d", i));

      step(12, 12, 1'b1, "reset_midstream");
      step(12, 12, 1'b0, "after_midstream_reset");

      // Operands changing between edges must not disturb the registered product
      for (int i = 0; i < 8; i++) begin
         int a0, b0;
         logic [9:0] held;
         a0 = int'($urandom_range(0, 31));
         b0 = int'($urandom_range(0, 31));
         step(a0, b0, 1'b0, "hold_load");
         held = ref_prod(a0, b0, 1'b0);
         #2;
         A = 5'($urandom);
         B = 5'($urandom);
         #1;
         check_val("hold_between_edges", P, held);
      end

      for (int a = 0; a < 32; a++)
         for (int b = 0; b < 32; b++)
            step(a, b, 1'b0, $sformatf("exhaustive_%0dx%0d", a, b));

      // Random operands with occasional reset pulses
      for (int i = 0; i < 300; i++)
         step(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              ($urandom_range(0, 15) == 0), "random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
